// File: rtl/k12a_lcd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : k12a_lcd_sequencer
//  Purpose  : HD44780 write sequencer (RS/data setup, EN pulse, hold, settle).
//             Define K12A_LCD_4BIT_EN to send each byte as two nibbles.
//  Revision : 1.0  initial release
// ============================================================================
module k12a_lcd_sequencer #(
    parameter int SETUP_CYCLES       = 2,
    parameter int PULSE_CYCLES       = 4,
    parameter int HOLD_CYCLES        = 2,
    parameter int SETTLE_CYCLES      = 10,
    parameter int SLOW_SETTLE_CYCLES = 50
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       xfer_req,
    input  logic       xfer_rs,
    input  logic [7:0] xfer_data,
    input  logic       overrun_clear,
    output logic       busy,
    output logic       overrun,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    // Counter reload values: each phase lasts load+1 cycles.
    localparam logic [15:0] c_SETUP_LOAD  = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] c_PULSE_LOAD  = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] c_HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] c_SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_SLOW_LOAD   = 16'(SLOW_SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_PULSE  = 3'd2,
        S_HOLD   = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_count;
    logic [15:0] w_count_next;
    logic [7:0]  r_byte;
    logic [7:0]  w_byte_next;
    logic        r_lcd_rs;
    logic        w_rs_next;
    logic [7:0]  r_lcd_data;
    logic [7:0]  w_data_next;
    logic        r_overrun;
    logic        w_overrun_next;
    logic        r_lcd_en;
    logic        r_busy;
    logic        w_count_zero;
    logic        w_slow;
`ifdef K12A_LCD_4BIT_EN
    logic        r_second;
    logic        w_second_next;
`endif

    assign w_count_zero = (r_count == 16'd0);
    // Clear display / return home need the long execution time.
    assign w_slow = !r_lcd_rs && ((r_byte == 8'h01) || (r_byte == 8'h02) || (r_byte == 8'h03));

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_byte_next    = r_byte;
        w_rs_next      = r_lcd_rs;
        w_data_next    = r_lcd_data;
        w_overrun_next = r_overrun;
`ifdef K12A_LCD_4BIT_EN
        w_second_next  = r_second;
`endif
        case (r_state)
            S_IDLE: begin
                if (xfer_req) begin
                    w_state_next = S_SETUP;
                    w_count_next = c_SETUP_LOAD;
                    w_byte_next  = xfer_data;
                    w_rs_next    = xfer_rs;
`ifdef K12A_LCD_4BIT_EN
                    w_data_next   = {xfer_data[7:4], 4'h0};
                    w_second_next = 1'b0;
`else
                    w_data_next  = xfer_data;
`endif
                end
            end
            S_SETUP: begin
                if (w_count_zero) begin
                    w_state_next = S_PULSE;
                    w_count_next = c_PULSE_LOAD;
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
            S_PULSE: begin
                if (w_count_zero) begin
                    w_state_next = S_HOLD;
                    w_count_next = c_HOLD_LOAD;
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
            S_HOLD: begin
                if (w_count_zero) begin
`ifdef K12A_LCD_4BIT_EN
                    if (!r_second) begin
                        w_state_next  = S_SETUP;
                        w_count_next  = c_SETUP_LOAD;
                        w_data_next   = {r_byte[3:0], 4'h0};
                        w_second_next = 1'b1;
                    end else begin
                        w_state_next = S_SETTLE;
                        w_count_next = w_slow ? c_SLOW_LOAD : c_SETTLE_LOAD;
                    end
`else
                    w_state_next = S_SETTLE;
                    w_count_next = w_slow ? c_SLOW_LOAD : c_SETTLE_LOAD;
`endif
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
            S_SETTLE: begin
                if (w_count_zero) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_count_next = r_count - 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_count_next = 16'd0;
            end
        endcase

        // A request landing mid-transfer is dropped; the set wins over a clear.
        if (overrun_clear) begin
            w_overrun_next = 1'b0;
        end
        if (xfer_req && (r_state != S_IDLE)) begin
            w_overrun_next = 1'b1;
        end
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            r_count    <= 16'd0;
            r_byte     <= 8'h00;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 8'h00;
            r_overrun  <= 1'b0;
            r_lcd_en   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_byte     <= w_byte_next;
            r_lcd_rs   <= w_rs_next;
            r_lcd_data <= w_data_next;
            r_overrun  <= w_overrun_next;
            // Decoded from the next state so EN/busy come straight off a flop.
            r_lcd_en   <= (w_state_next == S_PULSE);
            r_busy     <= (w_state_next != S_IDLE);
        end
    end

`ifdef K12A_LCD_4BIT_EN
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            r_second <= 1'b0;
        end else begin
            r_second <= w_second_next;
        end
    end
`endif

    assign busy     = r_busy;
    assign overrun  = r_overrun;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = r_lcd_en;
    assign lcd_data = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_k12a_lcd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_k12a_lcd_sequencer
//  Purpose  : Scoreboard bench for k12a_lcd_sequencer (honours K12A_LCD_4BIT_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_k12a_lcd_sequencer;

    localparam int SETUP  = 2;
    localparam int PULSE  = 4;
    localparam int HOLD   = 2;
    localparam int SETTLE = 10;
    localparam int SLOW   = 50;
    localparam int FRAME  = SETUP + PULSE + HOLD;

    logic       cpu_clock = 1'b0;
    logic       reset = 1'b0;
    logic       xfer_req = 1'b0;
    logic       xfer_rs = 1'b0;
    logic [7:0] xfer_data = 8'h00;
    logic       overrun_clear = 1'b0;
    logic       busy, overrun, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    k12a_lcd_sequencer #(
        .SETUP_CYCLES      (SETUP),
        .PULSE_CYCLES      (PULSE),
        .HOLD_CYCLES       (HOLD),
        .SETTLE_CYCLES     (SETTLE),
        .SLOW_SETTLE_CYCLES(SLOW)
    ) dut (
        .cpu_clock    (cpu_clock),
        .reset        (reset),
        .xfer_req     (xfer_req),
        .xfer_rs      (xfer_rs),
        .xfer_data    (xfer_data),
        .overrun_clear(overrun_clear),
        .busy         (busy),
        .overrun      (overrun),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_en       (lcd_en),
        .lcd_data     (lcd_data)
    );

    always #5 cpu_clock = ~cpu_clock;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         offset;
    } pulse_t;

    typedef struct {
        int         width;
        logic       rs;
        logic [7:0] last;
    } xfer_t;

    pulse_t pulse_q[$];
    xfer_t  xfer_q[$];

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_until = -1;
    logic exp_ovr = 1'b0;
    logic pend_ovr = 1'b0;
    logic mon_en = 1'b0;
    int   en_cnt = 0;
    int   busy_cnt = 0;
    logic prev_en = 1'b0;
    logic prev_busy = 1'b0;
    logic [7:0] cur_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what one accepted byte must look like on the LCD pins.
    task automatic model_accept(input logic rs, input logic [7:0] d, output int width);
        logic  slow;
        xfer_t x;
        slow  = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
`ifdef K12A_LCD_4BIT_EN
        pulse_q.push_back('{rs: rs, data: {d[7:4], 4'h0}, offset: SETUP});
        pulse_q.push_back('{rs: rs, data: {d[3:0], 4'h0}, offset: FRAME + SETUP});
        width  = 2 * FRAME + (slow ? SLOW : SETTLE);
        x.last = {d[3:0], 4'h0};
`else
        pulse_q.push_back('{rs: rs, data: d, offset: SETUP});
        width  = FRAME + (slow ? SLOW : SETTLE);
        x.last = d;
`endif
        x.width = width;
        x.rs    = rs;
        xfer_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge cpu_clock);
        cyc++;
        #1;
        exp_ovr       = pend_ovr;
        xfer_req      = 1'b0;
        overrun_clear = 1'b0;
    endtask

    // Present inputs for the next edge; decide acceptance from the model's timeline.
    task automatic drive(input logic req, input logic rs, input logic [7:0] d, input logic clr);
        int   e;
        int   w;
        logic accept;
        e             = cyc + 1;
        xfer_req      = req;
        xfer_rs       = rs;
        xfer_data     = d;
        overrun_clear = clr;
        accept        = req && (e > busy_until);
        if (accept) begin
            model_accept(rs, d, w);
            busy_until = e + w;
        end
        if (req && !accept) pend_ovr = 1'b1;
        else if (clr)       pend_ovr = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_free();
        int n;
        n = 0;
        while ((cyc + 1 <= busy_until) && (n < 400)) begin
            idle(1);
            n++;
        end
    endtask

    always @(negedge cpu_clock) begin
        pulse_t p;
        xfer_t  x;
        if (mon_en) begin
            check("lcd_rw", 32'(lcd_rw), 32'd0);
            check("overrun", 32'(overrun), 32'(exp_ovr));
            if (lcd_en && !prev_en) begin
                if (pulse_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_en: got pulse with data 0x%0h, expected none at %0t", lcd_data, $time);
                end else begin
                    p = pulse_q.pop_front();
                    check("en_rs", 32'(lcd_rs), 32'(p.rs));
                    check("en_data", 32'(lcd_data), 32'(p.data));
                    check("en_offset", 32'(busy_cnt), 32'(p.offset));
                    cur_data = p.data;
                end
            end
            if (!lcd_en && prev_en) begin
                check("en_width", 32'(en_cnt), 32'(PULSE));
                en_cnt = 0;
            end
            if (lcd_en) begin
                en_cnt++;
                check("en_data_stable", 32'(lcd_data), 32'(cur_data));
            end
            if (!busy && prev_busy) begin
                if (xfer_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_busy: got busy window of %0d, expected none at %0t", busy_cnt, $time);
                end else begin
                    x = xfer_q.pop_front();
                    check("busy_width", 32'(busy_cnt), 32'(x.width));
                    check("idle_data_held", 32'(lcd_data), 32'(x.last));
                    check("idle_rs_held", 32'(lcd_rs), 32'(x.rs));
                end
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
        end
        prev_en   = lcd_en;
        prev_busy = busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       rs;
        logic [7:0] d;
        int         n;

        #1 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(lcd_en), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_data", 32'(lcd_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        repeat (3) @(negedge cpu_clock);
        reset = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Directed: data byte, back-to-back slow command, back-to-back normal command.
        drive(1'b1, 1'b1, 8'h41, 1'b0);
        wait_free();
        drive(1'b1, 1'b0, 8'h01, 1'b0);
        wait_free();
        drive(1'b1, 1'b0, 8'h38, 1'b0);
        wait_free();
        drive(1'b1, 1'b1, 8'hA5, 1'b0);

        // Overrun: a request 5 cycles in is dropped; a clear in the same cycle loses.
        wait_free();
        idle(1);
        drive(1'b1, 1'b1, 8'h5A, 1'b0);
        idle(4);
        drive(1'b1, 1'b0, 8'h77, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 8'h66, 1'b1);
        idle(2);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        wait_free();
        idle(3);

        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 30)) drive(1'b0, 1'b0, 8'h00, ($urandom_range(0, 15) == 0));
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) == 0) wait_free();
            drive(1'b1, rs, d, ($urandom_range(0, 7) == 0));
        end

        // Reset during PULSE: EN and busy drop at once and the transfer is not resumed.
        wait_free();
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        idle(SETUP);
        check("pre_reset_en", 32'(lcd_en), 32'd1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_rst_en", 32'(lcd_en), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_data", 32'(lcd_data), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        pulse_q.delete();
        xfer_q.delete();
        pend_ovr   = 1'b0;
        exp_ovr    = 1'b0;
        busy_until = -1;
        en_cnt     = 0;
        busy_cnt   = 0;
        repeat (2) @(negedge cpu_clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("no_resume_busy", 32'(busy), 32'd0);
            check("no_resume_en", 32'(lcd_en), 32'd0);
        end
        mon_en = 1'b1;
        drive(1'b1, 1'b0, 8'h02, 1'b0);
        wait_free();
        drive(1'b1, 1'b1, 8'hC3, 1'b0);

        n = 0;
        while (((pulse_q.size() != 0) || (xfer_q.size() != 0) || busy) && (n < 500)) begin
            idle(1);
            n++;
        end
        idle(2);
        if ((pulse_q.size() != 0) || (xfer_q.size() != 0)) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d pulses and %0d transfers outstanding, expected 0", pulse_q.size(), xfer_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/k12a_lcd_sequencer.md
K12A_LCD_SEQUENCER -- requirements
Module: k12a_lcd_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, meaning the number of cycles RS/data are stable before EN rises (legal range 1..65535).
REQ-002 SHALL have parameter PULSE_CYCLES, default 4, meaning the EN high width in cycles (1..65535).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, meaning the number of cycles RS/data are held after EN falls (1..65535).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 10, meaning the execution wait after a normal transfer (1..65535).
REQ-005 SHALL have parameter SLOW_SETTLE_CYCLES, default 50, meaning the execution wait after a clear/home command (1..65535).
REQ-006 SHALL have ports (one per line: name, direction, width, meaning):
 cpu_clock  in  1  sole clock, all state updates on its rising edge
 reset  in  1  asynchronous, active-high reset
 xfer_req  in  1  one-cycle transfer request strobe from the IO block
 xfer_rs  in  1  0 = instruction, 1 = data; sampled with xfer_req
 xfer_data  in  8  byte to send; sampled with xfer_req
 overrun_clear  in  1  clears the overrun flag
 busy  out  1  high while a transfer is in progress
 overrun  out  1  sticky flag: a request arrived while busy
 lcd_rs  out  1  HD44780 register select
 lcd_rw  out  1  tied 0 (write only)
 lcd_en  out  1  HD44780 enable strobe
 lcd_data  out  8  HD44780 data bus

Function
REQ-007 SHALL implement states IDLE, SETUP, PULSE, HOLD and SETTLE with one shared 16-bit down-counter.
REQ-008 SHALL, when xfer_req=1 in IDLE, latch xfer_rs and xfer_data at that edge and enter SETUP.
REQ-009 SHALL drive lcd_rs and lcd_data from the latched values in every non-IDLE state, and hold their previous values in IDLE.
REQ-010 SHALL spend exactly SETUP_CYCLES in SETUP, PULSE_CYCLES in PULSE, HOLD_CYCLES in HOLD, and the selected settle count in SETTLE, then return to IDLE.
REQ-011 SHALL drive lcd_en=1 only in PULSE, from a registered signal with no glitches.
REQ-012 SHALL drive busy=1 in every non-IDLE state, giving a busy width of SETUP+PULSE+HOLD+settle cycles.
REQ-013 SHALL select SLOW_SETTLE_CYCLES when latched rs=0 and data is 0x01, 0x02 or 0x03, and SETTLE_CYCLES otherwise.
REQ-014 SHALL ignore xfer_req in any non-IDLE state, leave the transfer in progress unaffected, and set overrun=1.
REQ-015 SHALL accept an xfer_req on the first IDLE cycle after SETTLE, with no dead cycle.
REQ-016 SHALL give set priority when overrun_clear and a setting event occur in the same cycle, so overrun ends at 1.
REQ-017 SHALL drive lcd_rw=0 at all times.

Reset
REQ-018 SHALL, while reset=1, force state=IDLE, counter=0, busy=0, overrun=0, lcd_en=0, lcd_rs=0 and lcd_data=0x00, independent of cpu_clock.
REQ-019 SHALL abort a transfer in progress on reset, dropping lcd_en immediately, and SHALL not resume it after reset release.

Configuration
REQ-020 SHALL, when macro K12A_LCD_4BIT_EN is defined, send each byte as two nibbles: high nibble first, then low nibble.
REQ-021 SHALL, in 4-bit mode, present each nibble on lcd_data[7:4] with lcd_data[3:0]=0, run SETUP/PULSE/HOLD per nibble, go directly from the first HOLD to the second SETUP, and apply SETTLE only once after the second nibble.
REQ-022 SHALL, when K12A_LCD_4BIT_EN is undefined, send full 8-bit single transfers.

Verification (default parameters)
REQ-023 SHALL verify an 8-bit transfer: xfer_req with rs=1, data=0x41 -> lcd_data=0x41 and rs=1 for 8 cycles, lcd_en high for 4 cycles starting 2 cycles after acceptance, busy high for 18 cycles.
REQ-024 SHALL verify the slow-settle path: a request with rs=0, data=0x01 -> busy high for 58 cycles; with rs=0, data=0x38 -> busy high for 18 cycles.
REQ-025 SHALL verify overrun: a second request 5 cycles after the first -> ignored, lcd_data unchanged, overrun=1 until overrun_clear, then overrun=0.
REQ-026 SHALL verify back-to-back transfers: a request on the first cycle busy=0 -> accepted, busy has only a 1-cycle low gap, and the second byte appears on lcd_data.
REQ-027 SHALL verify reset during PULSE: assert reset -> lcd_en=0 and busy=0 asynchronously; after release the block is IDLE and accepts a new request.
REQ-028 SHALL verify 4-bit mode (K12A_LCD_4BIT_EN defined): data 0xA5 -> two EN pulses with lcd_data 0xA0 then 0x50, and busy high for 26 cycles.
